// File: rtl/pipe_adder_pkg.sv
// Shared constants, per-stage record and saturation limits for the pipelined adder.
// Saturation helpers are only referenced when PIPE_ADDER_SAT_EN is defined.
package pipe_adder_pkg;

  localparam int unsigned WIDTH_DEF  = 16;
  localparam int unsigned STAGES_DEF = 4;
  localparam int unsigned WIDTH_MAX  = 64;

  // Control travelling alongside each stage's partial sum.
  typedef struct packed {
    logic valid;
    logic carry;
    logic a_msb;
    logic b_msb;
  } stage_rec_t;

  // Largest positive two's-complement value of width w, right-aligned in 64 bits.
  function automatic logic [WIDTH_MAX-1:0] sat_max(input int unsigned w);
    return {1'b0, {(WIDTH_MAX-1){1'b1}}} >> (WIDTH_MAX - w);
  endfunction

  // Most negative two's-complement value of width w, right-aligned in 64 bits.
  function automatic logic [WIDTH_MAX-1:0] sat_min(input int unsigned w);
    return {{(WIDTH_MAX-1){1'b0}}, 1'b1} << (w - 1);
  endfunction

endpackage

// File: rtl/pipe_adder_if.sv
// Operand/result handshake bundle for pipe_adder.
// master drives operands and out_ready; slave is the adder.
interface pipe_adder_if
  import pipe_adder_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF
) ();

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             carry_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             carry_out;
  logic             overflow;

  modport master (
    output in_valid, a, b, carry_in, out_ready,
    input  in_ready, out_valid, sum, carry_out, overflow
  );

  modport slave (
    input  in_valid, a, b, carry_in, out_ready,
    output in_ready, out_valid, sum, carry_out, overflow
  );

endinterface

// File: rtl/pipe_adder_add_slice.sv
// Combinational CHUNK-bit ripple slice with carry in and carry out.
module add_slice #(
  parameter int unsigned CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout
);

  always_comb begin
    {cout, sum} = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};
  end

endmodule

// File: rtl/pipe_adder.sv
// Carry-pipelined adder: one CHUNK-bit slice per stage, global stall, valid/ready both ends.
// Define PIPE_ADDER_SAT_EN to saturate the sum on signed overflow.
module pipe_adder
  import pipe_adder_pkg::*;
#(
  parameter int unsigned WIDTH  = WIDTH_DEF,
  parameter int unsigned STAGES = STAGES_DEF
) (
  input logic         clk,
  input logic         rstn,
  pipe_adder_if.slave bus
);

  localparam int unsigned CHUNK = WIDTH / STAGES;

  if (WIDTH < 2 || WIDTH > WIDTH_MAX || STAGES < 1 || (WIDTH % STAGES) != 0) begin : g_bad_cfg
    $error("pipe_adder: WIDTH must be 2..64 and a multiple of STAGES");
  end

  stage_rec_t       rec_q   [STAGES];
  logic [WIDTH-1:0] sum_q   [STAGES];
  logic [WIDTH-1:0] a_q     [STAGES];
  logic [WIDTH-1:0] b_q     [STAGES];

  logic [WIDTH-1:0] a_in    [STAGES];
  logic [WIDTH-1:0] b_in    [STAGES];
  logic [WIDTH-1:0] s_in    [STAGES];
  logic             cin     [STAGES];
  logic             vin     [STAGES];
  logic [CHUNK-1:0] chunk_sum  [STAGES];
  logic             chunk_cout [STAGES];

  stage_rec_t       out_rec;
  logic [WIDTH-1:0] sum_raw;
  logic             ovf;
  logic             advance;

  assign out_rec = rec_q[STAGES-1];
  assign sum_raw = sum_q[STAGES-1];
  assign advance = !out_rec.valid || bus.out_ready;

  // Operands shift right by CHUNK each stage, so every slice adds the low bits of its input.
  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    if (k == 0) begin : g_first
      assign a_in[k] = bus.a;
      assign b_in[k] = bus.b;
      assign s_in[k] = '0;
      assign cin[k]  = bus.carry_in;
      assign vin[k]  = bus.in_valid;
    end else begin : g_next
      assign a_in[k] = a_q[k-1];
      assign b_in[k] = b_q[k-1];
      assign s_in[k] = sum_q[k-1];
      assign cin[k]  = rec_q[k-1].carry;
      assign vin[k]  = rec_q[k-1].valid;
    end

    add_slice #(.CHUNK(CHUNK)) u_slice (
      .a    (a_in[k][CHUNK-1:0]),
      .b    (b_in[k][CHUNK-1:0]),
      .cin  (cin[k]),
      .sum  (chunk_sum[k]),
      .cout (chunk_cout[k])
    );
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int unsigned k = 0; k < STAGES; k++) begin
        rec_q[k] <= '0;
        sum_q[k] <= '0;
        a_q[k]   <= '0;
        b_q[k]   <= '0;
      end
    end else if (advance) begin
      for (int unsigned k = 0; k < STAGES; k++) begin
        rec_q[k].valid <= vin[k];
        rec_q[k].carry <= chunk_cout[k];
        rec_q[k].a_msb <= a_in[k][CHUNK-1];
        rec_q[k].b_msb <= b_in[k][CHUNK-1];
        sum_q[k]       <= s_in[k] | (WIDTH'(chunk_sum[k]) << (k * CHUNK));
        a_q[k]         <= a_in[k] >> CHUNK;
        b_q[k]         <= b_in[k] >> CHUNK;
      end
    end
  end

  // The last slice consumed the true operand MSBs, so its record feeds the overflow test.
  assign ovf = (out_rec.a_msb == out_rec.b_msb) && (sum_raw[WIDTH-1] != out_rec.a_msb);

  assign bus.in_ready  = advance;
  assign bus.out_valid = out_rec.valid;
  assign bus.carry_out = out_rec.carry;
  assign bus.overflow  = ovf;

`ifdef PIPE_ADDER_SAT_EN
  localparam logic [WIDTH_MAX-1:0] SAT_HI = sat_max(WIDTH);
  localparam logic [WIDTH_MAX-1:0] SAT_LO = sat_min(WIDTH);

  always_comb begin
    bus.sum = sum_raw;
    if (ovf) begin
      bus.sum = out_rec.a_msb ? SAT_LO[WIDTH-1:0] : SAT_HI[WIDTH-1:0];
    end
  end
`else
  assign bus.sum = sum_raw;
`endif

endmodule

// File: tb/tb_pipe_adder.sv
// Directed bench for pipe_adder (WIDTH=16, STAGES=4) with immediate-assertion checks.
module tb_pipe_adder;

  logic clk;
  logic rstn;
  int   n_tests = 0;
  int   n_fail  = 0;

  pipe_adder_if #(.WIDTH(16)) bus ();

  pipe_adder #(.WIDTH(16), .STAGES(4)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef PIPE_ADDER_SAT_EN
  localparam logic [15:0] EXP_POS_OVF = 16'h7FFF;
  localparam logic [15:0] EXP_NEG_OVF = 16'h8000;
`else
  localparam logic [15:0] EXP_POS_OVF = 16'h8000;
  localparam logic [15:0] EXP_NEG_OVF = 16'h0000;
`endif

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One isolated operation: accept on the first edge, result visible after the fourth.
  task automatic run_single(input string tag, input logic [15:0] av, input logic [15:0] bv,
                            input logic cv, input logic [15:0] es, input logic ec, input logic eo);
    bus.in_valid  = 1'b1;
    bus.a         = av;
    bus.b         = bv;
    bus.carry_in  = cv;
    bus.out_ready = 1'b1;
    #1;
    check({tag, "_in_ready"}, 64'(bus.in_ready), 64'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check({tag, "_early"}, 64'(bus.out_valid), 64'd0);
    @(posedge clk); #1;
    check({tag, "_valid"}, 64'(bus.out_valid), 64'd1);
    check({tag, "_sum"},   64'(bus.sum),       64'(es));
    check({tag, "_cout"},  64'(bus.carry_out), 64'(ec));
    check({tag, "_ovf"},   64'(bus.overflow),  64'(eo));
    @(posedge clk); #1;
    check({tag, "_drained"}, 64'(bus.out_valid), 64'd0);
  endtask

  initial begin
    rstn          = 1'b1;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.carry_in  = 1'b0;
    bus.out_ready = 1'b0;

    // Reset: outputs clear before any clock edge.
    #1 rstn = 1'b0;
    #1;
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_in_ready",  64'(bus.in_ready),  64'd1);
    check("rst_sum",       64'(bus.sum),       64'd0);
    check("rst_cout",      64'(bus.carry_out), 64'd0);
    check("rst_ovf",       64'(bus.overflow),  64'd0);
    repeat (2) @(posedge clk);
    #3 rstn = 1'b1;

    // Single operations with hand-computed results.
    run_single("wrap_zero", 16'h0001, 16'hFFFF, 1'b0, 16'h0000, 1'b1, 1'b0);
    run_single("pos_ovf",   16'h7FFF, 16'h0001, 1'b0, EXP_POS_OVF, 1'b0, 1'b1);
    run_single("all_ones",  16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0);
    run_single("neg_ovf",   16'h8000, 16'h8000, 1'b0, EXP_NEG_OVF, 1'b1, 1'b1);
    run_single("ripple",    16'h0FFF, 16'h0001, 1'b0, 16'h1000, 1'b0, 1'b0);
    run_single("mixed_cin", 16'h1234, 16'h0F0F, 1'b1, 16'h2144, 1'b0, 1'b0);

    // Back-to-back stream: eight results on consecutive cycles, in order.
    bus.out_ready = 1'b1;
    bus.carry_in  = 1'b0;
    for (int c = 0; c < 12; c++) begin
      if (c < 8) begin
        bus.in_valid = 1'b1;
        bus.a        = 16'(c + 1);
        bus.b        = 16'(c);
      end else begin
        bus.in_valid = 1'b0;
      end
      @(posedge clk); #1;
      check("b2b_valid", 64'(bus.out_valid), 64'((c >= 3) && (c <= 10)));
      if (c >= 3 && c <= 10) check("b2b_sum", 64'(bus.sum), 64'(2 * (c - 3) + 1));
    end

    // Fill the pipe with out_ready low, stall three cycles, then drain.
    bus.out_ready = 1'b0;
    bus.b         = 16'h0101;
    for (int k = 0; k < 4; k++) begin
      bus.in_valid = 1'b1;
      bus.a        = 16'(16'h1111 * (k + 1));
      #1;
      check("fill_in_ready", 64'(bus.in_ready), 64'd1);
      @(posedge clk); #1;
    end
    bus.a = 16'h5555;
    #1;
    check("full_valid",    64'(bus.out_valid), 64'd1);
    check("full_in_ready", 64'(bus.in_ready),  64'd0);
    check("full_sum",      64'(bus.sum),       64'h1212);
    for (int s = 0; s < 3; s++) begin
      @(posedge clk); #1;
      check("stall_in_ready", 64'(bus.in_ready),  64'd0);
      check("stall_valid",    64'(bus.out_valid), 64'd1);
      check("stall_sum",      64'(bus.sum),       64'h1212);
    end
    bus.out_ready = 1'b1;
    #1;
    check("release_in_ready", 64'(bus.in_ready), 64'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    check("drain_sum0", 64'(bus.sum), 64'h2323);
    @(posedge clk); #1;
    check("drain_sum1", 64'(bus.sum), 64'h3434);
    @(posedge clk); #1;
    check("drain_sum2", 64'(bus.sum), 64'h4545);
    @(posedge clk); #1;
    check("drain_valid3", 64'(bus.out_valid), 64'd1);
    check("drain_sum3",   64'(bus.sum),       64'h5656);
    @(posedge clk); #1;
    check("drain_empty", 64'(bus.out_valid), 64'd0);

    // Mid-stream reset: three operations in flight, the oldest at the output.
    bus.b = 16'h0001;
    for (int k = 0; k < 3; k++) begin
      bus.in_valid = 1'b1;
      bus.a        = 16'(16'h0101 * (k + 1));
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    check("pre_rst_valid", 64'(bus.out_valid), 64'd1);
    check("pre_rst_sum",   64'(bus.sum),       64'h0102);
    #3 rstn = 1'b0;
    #1;
    check("async_rst_valid",    64'(bus.out_valid), 64'd0);
    check("async_rst_in_ready", 64'(bus.in_ready),  64'd1);
    check("async_rst_sum",      64'(bus.sum),       64'd0);
    @(posedge clk); #1;
    check("hold_rst_valid",    64'(bus.out_valid), 64'd0);
    check("hold_rst_in_ready", 64'(bus.in_ready),  64'd1);
    @(posedge clk);
    #3 rstn = 1'b1;

    // First operation after release: accepted on the next edge, no stale result ahead of it.
    run_single("post_rst", 16'h0005, 16'h0003, 1'b0, 16'h0008, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
